ep_rst_seq: RTL

//  Staged reset sequencer fed by the synchronised endpoint reset rst250 in the clk250 domain.

---
 rtl/ep_rst_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ep_rst_seq.sv
// Staged reset sequencer for the DMA sub-blocks in the clk250 domain.
// Releases cfg -> TX -> RX resets in order and re-runs the sequence after a drained soft reset.
module ep_rst_seq #(
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_GAP     = 8,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic clk250,
    input  logic rst250,
    input  logic soft_rst_req,
    input  logic tx_idle,
    input  logic rx_idle,
    output logic quiesce,
    output logic rst_cfg,
    output logic rst_tx,
    output logic rst_rx,
    output logic seq_busy,
    output logic drain_timeout
);

    localparam int MAX_A = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int MAX_P = (MAX_A > DRAIN_TIMEOUT) ? MAX_A : DRAIN_TIMEOUT;
    localparam int CNT_W = $clog2(MAX_P);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_GAP_TX,
        S_GAP_RX,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_quiesce, w_quiesce_nxt;
    logic             r_rst_cfg, w_rst_cfg_nxt;
    logic             r_rst_tx, w_rst_tx_nxt;
    logic             r_rst_rx, w_rst_rx_nxt;
    logic             r_seq_busy, w_seq_busy_nxt;
    logic             r_drain_to, w_drain_to_nxt;

    always_ff @(posedge clk250 or posedge rst250) begin
        if (rst250) begin
            r_state    <= S_HOLD;
            r_cnt      <= '0;
            r_quiesce  <= 1'b0;
            r_rst_cfg  <= 1'b1;
            r_rst_tx   <= 1'b1;
            r_rst_rx   <= 1'b1;
            r_seq_busy <= 1'b1;
            r_drain_to <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_quiesce  <= w_quiesce_nxt;
            r_rst_cfg  <= w_rst_cfg_nxt;
            r_rst_tx   <= w_rst_tx_nxt;
            r_rst_rx   <= w_rst_rx_nxt;
            r_seq_busy <= w_seq_busy_nxt;
            r_drain_to <= w_drain_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + CNT_ONE;
        w_quiesce_nxt  = r_quiesce;
        w_rst_cfg_nxt  = r_rst_cfg;
        w_rst_tx_nxt   = r_rst_tx;
        w_rst_rx_nxt   = r_rst_rx;
        w_seq_busy_nxt = r_seq_busy;
        w_drain_to_nxt = r_drain_to;

        case (r_state)
            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_rst_cfg_nxt = 1'b0;
                    w_state_nxt   = S_GAP_TX;
                end
            end
            S_GAP_TX: begin
                if (r_cnt == GAP_LAST) begin
                    w_rst_tx_nxt = 1'b0;
                    w_state_nxt  = S_GAP_RX;
                end
            end
            S_GAP_RX: begin
                if (r_cnt == GAP_LAST) begin
                    w_rst_rx_nxt   = 1'b0;
                    w_seq_busy_nxt = 1'b0;
                    w_state_nxt    = S_RUN;
                end
            end
            S_RUN: begin
                // Counter parks in RUN so it can never wrap while the link is up.
                w_cnt_nxt = r_cnt;
                if (soft_rst_req) begin
                    w_quiesce_nxt  = 1'b1;
                    w_seq_busy_nxt = 1'b1;
                    w_drain_to_nxt = 1'b0;
                    w_state_nxt    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Idle is checked first so a drain finishing on the timeout edge is not flagged.
                if ((tx_idle && rx_idle) || (r_cnt == DRAIN_LAST)) begin
                    w_rst_cfg_nxt  = 1'b1;
                    w_rst_tx_nxt   = 1'b1;
                    w_rst_rx_nxt   = 1'b1;
                    w_quiesce_nxt  = 1'b0;
                    w_drain_to_nxt = !(tx_idle && rx_idle);
                    w_state_nxt    = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end
    end

    assign quiesce       = r_quiesce;
    assign rst_cfg       = r_rst_cfg;
    assign rst_tx        = r_rst_tx;
    assign rst_rx        = r_rst_rx;
    assign seq_busy      = r_seq_busy;
    assign drain_timeout = r_drain_to;

endmodule
